t05_cb_serializer: RTL and testbench

T05_CB_SERIALIZER -- requirements
Module: t05_cb_serializer

---
 rtl/t05_cb_serializer_pkg.sv | 24 ++
 rtl/t05_msb_locate.sv | 21 ++
 rtl/t05_cb_serializer.sv | 139 +++++++++++++
 tb/tb_t05_cb_serializer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_cb_serializer_pkg.sv
// Shared definitions for the codebook serializer: controller phase code,
// path width, FSM state encoding and a byte-count helper.
package t05_pkg;

    localparam int         PATH_W  = 128;
    localparam logic [3:0] EN_CODE = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCATE,
        ST_HDR_CHAR,
        ST_HDR_LEN,
        ST_BITS,
        ST_DONE
    } state_e;

    // Number of payload bytes needed for a code of len bits (ceil(len/8)).
    function automatic logic [4:0] code_bytes(input logic [6:0] len);
        logic [7:0] t;
        t = {1'b0, len} + 8'd7;
        return t[7:3];
    endfunction

endpackage

// File: rtl/t05_msb_locate.sv
// Highest-set-bit encoder: reports the bit position of the leading 1 and
// flags an all-zero input.
module t05_msb_locate #(
    parameter int PATH_W = 128
) (
    input  logic [PATH_W-1:0] path,
    output logic [6:0]        pos,
    output logic              zero
);

    // Later iterations override earlier ones, so the highest set bit wins.
    always_comb begin
        pos = '0;
        for (int i = 0; i < PATH_W; i++) begin
            if (path[i]) pos = 7'(i);
        end
    end

    assign zero = ~|path;

endmodule

// File: rtl/t05_cb_serializer.sv
// Codebook serializer: records each found leaf into the codebook table and
// streams an index/length/code-bits record to the SPI writer.
module t05_cb_serializer
    import t05_pkg::*;
#(
    parameter int         PATH_W  = t05_pkg::PATH_W,
    parameter logic [3:0] EN_CODE = t05_pkg::EN_CODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        en_state,
    input  logic              char_found,
    input  logic [7:0]        char_index,
    input  logic [PATH_W-1:0] char_path,
    output logic [7:0]        wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              cb_we,
    output logic [7:0]        cb_addr,
    output logic [6:0]        cb_len,
    output logic [PATH_W-1:0] cb_code,
    output logic              write_finish,
    output logic              busy,
    output logic              overrun
);

    localparam logic [PATH_W-1:0] ONE = {{(PATH_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic              en, xfer;
    logic [7:0]        idx_q;
    logic [PATH_W-1:0] path_q;
    logic [PATH_W-1:0] sh_q;
    logic [PATH_W-1:0] code_clr;
    logic [6:0]        len_q;
    logic [4:0]        cnt_q;
    logic [6:0]        loc_pos;
    logic              loc_zero;

    t05_msb_locate #(.PATH_W(PATH_W)) u_locate (
        .path (path_q),
        .pos  (loc_pos),
        .zero (loc_zero)
    );

    assign en       = (en_state == EN_CODE);
    assign xfer     = en && wr_valid && wr_ready;
    assign code_clr = path_q & ~(ONE << loc_pos);

    assign cb_we        = en && (state_q == ST_LOCATE) && !loc_zero;
    assign cb_addr      = idx_q;
    assign cb_len       = loc_pos;
    assign cb_code      = code_clr;
    assign write_finish = en && (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                ST_IDLE:     if (char_found) state_d = ST_LOCATE;
                ST_LOCATE:   state_d = loc_zero ? ST_DONE : ST_HDR_CHAR;
                ST_HDR_CHAR: if (xfer) state_d = ST_HDR_LEN;
                ST_HDR_LEN:  if (xfer) state_d = (len_q != '0) ? ST_BITS : ST_DONE;
                ST_BITS:     if (xfer && cnt_q == 5'd1) state_d = ST_DONE;
                ST_DONE:     state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            path_q   <= '0;
            sh_q     <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            wr_data  <= '0;
            wr_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (char_found) begin
                        idx_q  <= char_index;
                        path_q <= char_path;
                    end
                end
                ST_LOCATE: begin
                    len_q <= loc_pos;
                    cnt_q <= code_bytes(loc_pos);
                    // Left-align the code so payload bytes come off the top, MSB first.
                    sh_q  <= code_clr << (PATH_W - int'(loc_pos));
                    if (loc_zero) begin
                        overrun <= 1'b1;
                    end else begin
                        wr_valid <= 1'b1;
                        wr_data  <= idx_q;
                    end
                end
                ST_HDR_CHAR: begin
                    if (xfer) wr_data <= {1'b0, len_q};
                end
                ST_HDR_LEN: begin
                    if (xfer) begin
                        if (len_q != '0) begin
                            wr_data <= sh_q[PATH_W-1 -: 8];
                            sh_q    <= sh_q << 8;
                        end else begin
                            wr_valid <= 1'b0;
                            wr_data  <= '0;
                        end
                    end
                end
                ST_BITS: begin
                    if (xfer) begin
                        if (cnt_q == 5'd1) begin
                            wr_valid <= 1'b0;
                            wr_data  <= '0;
                        end else begin
                            wr_data <= sh_q[PATH_W-1 -: 8];
                            sh_q    <= sh_q << 8;
                            cnt_q   <= cnt_q - 5'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (char_found && state_q != ST_IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_t05_cb_serializer.sv
// Directed bench for t05_cb_serializer: fixed records with hand-computed
// byte streams, codebook writes, latencies and sticky-flag behaviour.
module tb_t05_cb_serializer;

    localparam int PW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    en_state;
    logic          char_found;
    logic [7:0]    char_index;
    logic [PW-1:0] char_path;
    logic [7:0]    wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic          cb_we;
    logic [7:0]    cb_addr;
    logic [6:0]    cb_len;
    logic [PW-1:0] cb_code;
    logic          write_finish;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;

    t05_cb_serializer #(.PATH_W(PW), .EN_CODE(4'd4)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_state     (en_state),
        .char_found   (char_found),
        .char_index   (char_index),
        .char_path    (char_path),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .cb_we        (cb_we),
        .cb_addr      (cb_addr),
        .cb_len       (cb_len),
        .cb_code      (cb_code),
        .write_finish (write_finish),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte capture and stall-stability checking, sampled mid-cycle.
    always @(negedge clk) begin
        if (stall_prev && !rst && en_state == 4'd4) begin
            check("stall_valid", PW'(wr_valid), PW'(1));
            check("stall_data", PW'(wr_data), PW'(stall_data));
        end
        stall_prev = !rst && en_state == 4'd4 && wr_valid && !wr_ready;
        stall_data = wr_data;
        if (!rst && en_state == 4'd4 && wr_valid && wr_ready) cap_q.push_back(wr_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cap_q.delete();
    endtask

    // Pulse char_found for one cycle; returns with the DUT in its LOCATE cycle.
    task automatic send(input logic [7:0] idx, input logic [PW-1:0] path, output int start);
        char_index = idx;
        char_path  = path;
        char_found = 1'b1;
        start      = cyc;
        tick();
        char_found = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input bit toggle, input int start, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (write_finish) begin
                seen = 1'b1;
                lat  = cyc - start;
            end else begin
                if (toggle) wr_ready = ~wr_ready;
                tick();
            end
        end
        wr_ready = 1'b1;
        check({tag, "_finish_seen"}, PW'(seen), PW'(1));
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_count"}, PW'(cap_q.size()), PW'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_q.size()) check($sformatf("%s_byte%0d", tag, i), PW'(cap_q[i]), PW'(exp_q[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int lat;
        rst        = 1'b1;
        en_state   = 4'd4;
        char_found = 1'b0;
        char_index = '0;
        char_path  = '0;
        wr_ready   = 1'b1;
        do_reset();

        check("rst_busy", PW'(busy), PW'(0));
        check("rst_wr_valid", PW'(wr_valid), PW'(0));
        check("rst_wr_data", PW'(wr_data), PW'(0));
        check("rst_cb_we", PW'(cb_we), PW'(0));
        check("rst_cb_addr", PW'(cb_addr), PW'(0));
        check("rst_cb_len", PW'(cb_len), PW'(0));
        check("rst_cb_code", cb_code, PW'(0));
        check("rst_finish", PW'(write_finish), PW'(0));
        check("rst_overrun", PW'(overrun), PW'(0));

        // Basic 3-bit code 101.
        send(8'h41, PW'('b1101), st);
        check("r1_cb_we", PW'(cb_we), PW'(1));
        check("r1_cb_addr", PW'(cb_addr), PW'(8'h41));
        check("r1_cb_len", PW'(cb_len), PW'(3));
        check("r1_cb_code", cb_code, PW'('b101));
        wait_finish("r1", 1'b0, st, lat);
        check("r1_latency", PW'(lat), PW'(5));
        exp_q = '{8'h41, 8'h03, 8'hA0};
        check_bytes("r1");
        tick();
        check("r1_finish_pulse", PW'(write_finish), PW'(0));
        check("r1_idle", PW'(busy), PW'(0));

        // 11-bit code with backpressure.
        cap_q.delete();
        send(8'h41, PW'(12'h801), st);
        check("r2_cb_len", PW'(cb_len), PW'(11));
        check("r2_cb_code", cb_code, PW'(1));
        wait_finish("r2", 1'b1, st, lat);
        exp_q = '{8'h41, 8'h0B, 8'h00, 8'h20};
        check_bytes("r2");
        tick();

        // Zero-length code: header only.
        cap_q.delete();
        send(8'h7E, PW'(1), st);
        check("r3_cb_we", PW'(cb_we), PW'(1));
        check("r3_cb_len", PW'(cb_len), PW'(0));
        check("r3_cb_code", cb_code, PW'(0));
        wait_finish("r3", 1'b0, st, lat);
        check("r3_latency", PW'(lat), PW'(4));
        exp_q = '{8'h7E, 8'h00};
        check_bytes("r3");
        tick();

        // Empty path: no record, overrun set.
        cap_q.delete();
        send(8'h10, PW'(0), st);
        check("r4_cb_we", PW'(cb_we), PW'(0));
        wait_finish("r4", 1'b0, st, lat);
        check("r4_latency", PW'(lat), PW'(2));
        check("r4_overrun", PW'(overrun), PW'(1));
        exp_q.delete();
        check_bytes("r4");
        tick();

        // Overlapping char_found and a frozen phase mid-record.
        do_reset();
        send(8'h55, PW'(16'hABCD), st);
        check("r5_cb_len", PW'(cb_len), PW'(15));
        check("r5_cb_code", cb_code, PW'(16'h2BCD));
        tick();
        tick();
        tick();
        char_index = 8'h66;
        char_path  = PW'(8'hFF);
        char_found = 1'b1;
        tick();
        char_found = 1'b0;
        en_state   = 4'd3;
        for (int i = 0; i < 5; i++) tick();
        check("r5_frozen_busy", PW'(busy), PW'(1));
        check("r5_frozen_finish", PW'(write_finish), PW'(0));
        en_state = 4'd4;
        wait_finish("r5", 1'b0, st, lat);
        exp_q = '{8'h55, 8'h0F, 8'h57, 8'h9A};
        check_bytes("r5");
        check("r5_overrun", PW'(overrun), PW'(1));
        tick();
        check("r5_idle", PW'(busy), PW'(0));

        // Reset during the length header, then a clean record.
        do_reset();
        send(8'h33, PW'(8'hF0), st);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("r6_busy", PW'(busy), PW'(0));
        check("r6_wr_valid", PW'(wr_valid), PW'(0));
        check("r6_wr_data", PW'(wr_data), PW'(0));
        check("r6_cb_addr", PW'(cb_addr), PW'(0));
        check("r6_cb_code", cb_code, PW'(0));
        check("r6_finish", PW'(write_finish), PW'(0));
        rst = 1'b0;
        cap_q.delete();
        send(8'h42, PW'('b10), st);
        check("r7_cb_len", PW'(cb_len), PW'(1));
        wait_finish("r7", 1'b0, st, lat);
        check("r7_latency", PW'(lat), PW'(5));
        exp_q = '{8'h42, 8'h01, 8'h00};
        check_bytes("r7");
        check("r7_overrun", PW'(overrun), PW'(0));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
